// File: rtl/wb_periph_fabric.sv
// Wishbone peripheral fabric: decodes one master onto NUM_SLAVES slaves,
// registers the slave response, times out hung or unmapped accesses, and
// aggregates per-slave interrupts through a small maskable CSR bank.
module wb_periph_fabric #(
    parameter int                         NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0]   BASE_ADRS  = {32'h30300000, 32'h30200000,
                                                        32'h30100000, 32'h30000000},
    parameter logic [31:0]                ADR_MASK   = 32'hFFF00000,
    parameter logic [31:0]                CSR_BASE   = 32'h30F00000,
    parameter int                         TIMEOUT    = 255,
    parameter logic [31:0]                ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [31:0]              wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [31:0]              wb_dat_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    output logic [3:0]               s_sel_o,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES*32-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    irq_i,
    output logic                     interrupt_o
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_CSR,
        ST_ERR,
        ST_DONE
    } state_e;

    state_e                  state_q;
    logic [SW-1:0]           sel_q;
    logic [7:0]              cnt_q;
    logic                    ack_q;
    logic [31:0]             dat_q;
    logic [NUM_SLAVES-1:0]   mask_q;
    logic                    to_flag_q;
    logic [31:0]             to_adr_q;
    logic                    irq_q;

    logic                    csr_hit;
    logic                    slv_hit;
    logic [SW-1:0]           hit_idx;
    logic [31:0]             csr_rdata;
    logic                    sel_ack;
    logic [31:0]             sel_dat;

    // Address decode: CSR window wins, otherwise lowest-index matching slave.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        csr_hit = ((wb_adr_i & ADR_MASK) == CSR_BASE);
        slv_hit = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((wb_adr_i & ADR_MASK) == BASE_ADRS[32*i +: 32]) begin
                slv_hit = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    // CSR read mux: STATUS, MASK, TO_ADR, reserved.
    always_comb begin
        csr_rdata = '0;
        case (wb_adr_i[3:2])
            2'd0: begin
                csr_rdata[NUM_SLAVES-1:0] = irq_i;
                csr_rdata[31]             = to_flag_q;
            end
            2'd1:    csr_rdata[NUM_SLAVES-1:0] = mask_q;
            2'd2:    csr_rdata = to_adr_q;
            default: csr_rdata = '0;
        endcase
    end

    assign sel_ack = s_ack_i[sel_q];
    assign sel_dat = s_dat_i[32*sel_q +: 32];

    // Transaction FSM with registered ack/data, timeout capture and CSR bank.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            mask_q    <= '1;
            to_flag_q <= 1'b0;
            to_adr_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= |(irq_i & mask_q);
            ack_q <= 1'b0;
            dat_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        if (csr_hit) begin
                            state_q <= ST_CSR;
                        end else if (slv_hit) begin
                            state_q <= ST_ACTIVE;
                            sel_q   <= hit_idx;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!wb_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (sel_ack) begin
                        ack_q   <= 1'b1;
                        dat_q   <= sel_dat;
                        state_q <= ST_DONE;
                    end else if (cnt_q == 8'(TIMEOUT)) begin
                        ack_q     <= 1'b1;
                        dat_q     <= ERR_DATA;
                        to_flag_q <= 1'b1;
                        to_adr_q  <= wb_adr_i;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_CSR: begin
                    if (!wb_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        ack_q   <= 1'b1;
                        dat_q   <= csr_rdata;
                        state_q <= ST_DONE;
                        if (wb_we_i) begin
                            case (wb_adr_i[3:2])
                                2'd0: if (wb_dat_i[31]) to_flag_q <= 1'b0;
                                2'd1: if (wb_sel_i[0]) mask_q <= wb_dat_i[NUM_SLAVES-1:0];
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ERR: begin
                    if (!wb_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        ack_q   <= 1'b1;
                        dat_q   <= ERR_DATA;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign s_cyc_o     = (state_q == ST_ACTIVE) ? (NUM_SLAVES'(1) << sel_q) : '0;
    assign s_stb_o     = s_cyc_o;
    assign s_we_o      = wb_we_i && (state_q == ST_ACTIVE);
    assign s_adr_o     = wb_adr_i;
    assign s_dat_o     = wb_dat_i;
    assign s_sel_o     = wb_sel_i;
    assign interrupt_o = irq_q;

endmodule

// File: tb/tb_wb_periph_fabric.sv
// Self-checking bench for wb_periph_fabric: behavioural slaves with
// programmable ack delay, a master task and a scoreboard of expected read data.
module tb_wb_periph_fabric;

    localparam int          N      = 4;
    localparam int          TO     = 20;
    localparam logic [31:0] ERRD   = 32'hDEADBEEF;
    localparam logic [31:0] CSRB   = 32'h30F00000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     wb_adr = '0;
    logic [31:0]     wb_wdat = '0;
    logic [3:0]      wb_sel = '0;
    logic            wb_we = 1'b0;
    logic            wb_cyc = 1'b0;
    logic            wb_stb = 1'b0;
    logic            wb_ack;
    logic [31:0]     wb_rdat;
    logic [N-1:0]    s_cyc, s_stb, s_ack;
    logic            s_we;
    logic [31:0]     s_adr, s_dat;
    logic [3:0]      s_sel;
    logic [N*32-1:0] s_rdat;
    logic [N-1:0]    irq = '0;
    logic            intr;

    int              slave_delay[N];
    logic [31:0]     slave_data[N];
    int              scnt[N];

    int              total = 0;
    int              bad = 0;
    int              ack_cnt = 0;
    int              exp_acks = 0;
    logic [31:0]     exp_q[$];

    wb_periph_fabric #(
        .NUM_SLAVES(N),
        .BASE_ADRS ({32'h30000000, 32'h30200000, 32'h30100000, 32'h30000000}),
        .TIMEOUT   (TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_wdat),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_cyc_i   (wb_cyc),
        .wb_stb_i   (wb_stb),
        .wb_ack_o   (wb_ack),
        .wb_dat_o   (wb_rdat),
        .s_cyc_o    (s_cyc),
        .s_stb_o    (s_stb),
        .s_we_o     (s_we),
        .s_adr_o    (s_adr),
        .s_dat_o    (s_dat),
        .s_sel_o    (s_sel),
        .s_ack_i    (s_ack),
        .s_dat_i    (s_rdat),
        .irq_i      (irq),
        .interrupt_o(intr)
    );

    always #5 clk = ~clk;

    // Slave model: count cycles of strobe, ack when count reaches the delay.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) scnt[i] <= s_stb[i] ? scnt[i] + 1 : 0;
    end

    always_comb begin
        s_ack  = '0;
        s_rdat = '0;
        for (int i = 0; i < N; i++) begin
            s_ack[i]          = s_stb[i] && (scnt[i] == slave_delay[i]);
            s_rdat[32*i +: 32] = slave_data[i];
        end
    end

    // Count every master ack pulse seen by the bus.
    always @(posedge clk) begin
        if (wb_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One master access; call just after a rising edge.
    task automatic bus(input string tag, input logic [31:0] adr, input logic we,
                       input logic [31:0] wdat, input logic [3:0] sel, input bit chk_dat,
                       input logic [31:0] exp_dat, input int exp_lat, input logic [N-1:0] exp_stb);
        int         lat;
        bit         got;
        logic [N-1:0] stb_seen;
        wb_adr  = adr;
        wb_we   = we;
        wb_wdat = wdat;
        wb_sel  = sel;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        if (chk_dat) exp_q.push_back(exp_dat);
        lat      = 0;
        got      = 1'b0;
        stb_seen = '0;
        while (!got && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            stb_seen |= s_stb;
            if (wb_ack) got = 1'b1;
        end
        if (!got) begin
            check({tag, "_ack_wait"}, 32'(wb_ack), 32'd1);
        end else begin
            exp_acks++;
            if (chk_dat) check({tag, "_dat"}, wb_rdat, exp_q.pop_front());
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_stb"}, 32'(stb_seen), 32'(exp_stb));
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_pulse"}, 32'(wb_ack), 32'd0);
        check({tag, "_dat_idle"}, wb_rdat, 32'd0);
    endtask

    task automatic csr_rd(input string tag, input int off, input logic [31:0] exp);
        bus(tag, CSRB + 32'(off * 4), 1'b0, 32'd0, 4'hF, 1'b1, exp, 2, '0);
    endtask

    task automatic csr_wr(input string tag, input int off, input logic [31:0] d, input logic [3:0] sel);
        bus(tag, CSRB + 32'(off * 4), 1'b1, d, sel, 1'b0, 32'd0, 2, '0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            slave_delay[i] = 0;
            slave_data[i]  = 32'hA0A0_0000 + 32'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_dat", wb_rdat, 32'd0);
        check("rst_cyc", 32'(s_cyc), 32'd0);
        check("rst_stb", 32'(s_stb), 32'd0);
        check("rst_we", 32'(s_we), 32'd0);
        check("rst_irq", 32'(intr), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        csr_rd("mask_rst", 1, 32'h0000000F);
        csr_rd("status_rst", 0, 32'h0);

        // Slave 1 read acking three cycles after its strobe.
        slave_delay[1] = 3;
        slave_data[1]  = 32'h12345678;
        bus("s1_rd", 32'h30100010, 1'b0, 32'd0, 4'hF, 1'b1, 32'h12345678, 5, 4'b0010);

        // Slave 2 write acking immediately.
        slave_delay[2] = 0;
        bus("s2_wr", 32'h30200004, 1'b1, 32'h55AA55AA, 4'hF, 1'b1, slave_data[2], 2, 4'b0100);

        // Unmapped write: error response, no slave strobe, no timeout flag.
        bus("unmapped", 32'h40000000, 1'b1, 32'h1, 4'hF, 1'b1, ERRD, 2, '0);
        csr_rd("status_unm", 0, 32'h0);

        // Overlapping base for slaves 0 and 3: slave 0 wins.
        slave_delay[0] = 1;
        bus("overlap", 32'h30000020, 1'b0, 32'd0, 4'hF, 1'b1, slave_data[0], 3, 4'b0001);

        // Hung slave 2: timeout, flag, captured address, W1C.
        slave_delay[2] = -1;
        bus("timeout", 32'h30200044, 1'b0, 32'd0, 4'hF, 1'b1, ERRD, TO + 2, 4'b0100);
        csr_rd("status_to", 0, 32'h80000000);
        csr_rd("to_adr", 2, 32'h30200044);
        csr_rd("reserved", 3, 32'h0);
        csr_wr("w1c", 0, 32'h80000000, 4'hF);
        csr_rd("status_clr", 0, 32'h0);

        // Interrupt masking.
        irq = 4'b0100;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("irq_unmasked", 32'(intr), 32'd1);
        csr_wr("mask_b", 1, 32'h0000000B, 4'b0001);
        check("irq_masked", 32'(intr), 32'd0);
        csr_wr("mask_nosel", 1, 32'h00000004, 4'b0000);
        csr_rd("mask_keep", 1, 32'h0000000B);
        check("irq_still_masked", 32'(intr), 32'd0);
        csr_rd("status_irq", 0, 32'h00000004);
        csr_wr("mask_4", 1, 32'h00000004, 4'b0001);
        check("irq_enabled", 32'(intr), 32'd1);

        // Abort in ACTIVE: master drops cyc, fabric returns idle, no ack.
        slave_delay[1] = -1;
        wb_adr = 32'h30100000;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_stb", 32'(s_stb), 32'b0010);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle", 32'(s_stb), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_ack", ack_cnt, exp_acks);

        // Reset while ACTIVE.
        wb_adr = 32'h30200008;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_stb", 32'(s_stb), 32'b0100);
        rst = 1'b1;
        #1;
        check("mid_rst_stb", 32'(s_stb), 32'd0);
        check("mid_rst_cyc", 32'(s_cyc), 32'd0);
        check("mid_rst_irq", 32'(intr), 32'd0);
        check("mid_rst_ack", 32'(wb_ack), 32'd0);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_no_ack", ack_cnt, exp_acks);
        csr_rd("mask_after_rst", 1, 32'h0000000F);

        check("ack_total", ack_cnt, exp_acks);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
